// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module      : regfile_multiport
// Description : Integer register file with two registered read ports, one
//               write port and a post-reset hardware clear sequencer.
//               Optional write-to-read bypass: define REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_multiport #(
    parameter int BITS     = 64,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [BITS-1:0]   rd_data_a,
    output logic [BITS-1:0]   rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BITS-1:0]   wr_data,
    output logic              ready
);

    localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clear_ptr;
    logic [BITS-1:0]   r_mem [NUM_REGS];

    logic              w_wr_ok;
    logic              w_rd_ok_a;
    logic              w_rd_ok_b;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [BITS-1:0]   w_mem_data;
    logic [BITS-1:0]   w_rd_nxt_a;
    logic [BITS-1:0]   w_rd_nxt_b;

    // An address is live only if it is in range and not the hardwired zero entry.
    assign w_wr_ok   = (r_state == ST_READY) && wr_en
                     && ({1'b0, wr_addr} < c_DEPTH)
                     && !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_rd_ok_a = ({1'b0, rd_addr_a} < c_DEPTH)
                     && !((ZERO_REG != 0) && (rd_addr_a == '0));
    assign w_rd_ok_b = ({1'b0, rd_addr_b} < c_DEPTH)
                     && !((ZERO_REG != 0) && (rd_addr_b == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_CLEAR;
            r_clear_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clear_ptr <= r_clear_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clear_ptr == c_LAST_IDX) w_state_nxt = ST_READY;
            ST_READY: w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    assign ready = (r_state == ST_READY);

    // Single storage write port shared between the clear sequencer and rd.
    always_comb begin
        w_mem_we   = w_wr_ok;
        w_mem_addr = wr_addr;
        w_mem_data = wr_data;
        if (r_state == ST_CLEAR) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_clear_ptr;
            w_mem_data = '0;
        end
    end

    // Storage is deliberately not reset; the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    always_comb begin
        w_rd_nxt_a = '0;
        w_rd_nxt_b = '0;
        if (r_state == ST_READY) begin
            if (w_rd_ok_a) begin
                w_rd_nxt_a = r_mem[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
                if (w_wr_ok && (wr_addr == rd_addr_a)) w_rd_nxt_a = wr_data;
`endif
            end
            if (w_rd_ok_b) begin
                w_rd_nxt_b = r_mem[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
                if (w_wr_ok && (wr_addr == rd_addr_b)) w_rd_nxt_b = wr_data;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_data_a <= w_rd_nxt_a;
            rd_data_b <= w_rd_nxt_b;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_multiport
// Description : Directed self-checking bench for regfile_multiport (32-entry
//               and 24-entry instances); honours REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_multiport;

    logic        clk;
    logic        rst;
    logic [4:0]  ra_a, ra_b, wa;
    logic        we;
    logic [63:0] wd;
    logic [63:0] rda, rdb;
    logic        rdy;

    logic [4:0]  ra24_a, ra24_b, wa24;
    logic        we24;
    logic [63:0] wd24;
    logic [63:0] rda24, rdb24;
    logic        rdy24;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_byp;

    regfile_multiport #(.BITS(64), .NUM_REGS(32), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_a(ra_a), .rd_addr_b(ra_b),
        .rd_data_a(rda), .rd_data_b(rdb),
        .wr_en(we), .wr_addr(wa), .wr_data(wd),
        .ready(rdy)
    );

    regfile_multiport #(.BITS(64), .NUM_REGS(24), .ZERO_REG(1)) dut24 (
        .clk(clk), .rst(rst),
        .rd_addr_a(ra24_a), .rd_addr_b(ra24_b),
        .rd_data_a(rda24), .rd_data_b(rdb24),
        .wr_en(we24), .wr_addr(wa24), .wr_data(wd24),
        .ready(rdy24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ra_a = '0; ra_b = '0; wa = '0; we = 1'b0; wd = '0;
        ra24_a = '0; ra24_b = '0; wa24 = '0; we24 = 1'b0; wd24 = '0;
        tick();
        tick();
        check_value("reset_ready", {63'd0, rdy}, 64'd0);
        check_value("reset_rd_a", rda, 64'd0);
        check_value("reset_rd_b", rdb, 64'd0);

        // Release reset; writes attempted during clear must be ignored.
        rst = 1'b0;
        we = 1'b1; wa = 5'd9; wd = 64'hAA;
        for (int i = 1; i <= 32; i++) begin
            tick();
            check_value($sformatf("clear_ready_%0d", i), {63'd0, rdy},
                        (i < 32) ? 64'd0 : 64'd1);
            check_value($sformatf("clear_rd_a_%0d", i), rda, 64'd0);
            if (i == 23) check_value("clear24_not_ready", {63'd0, rdy24}, 64'd0);
            if (i == 24) check_value("clear24_ready", {63'd0, rdy24}, 64'd1);
        end
        we = 1'b0;

        // Every entry reads zero after clear (includes x9 written during clear).
        for (int i = 0; i < 32; i++) begin
            ra_a = 5'(i);
            ra_b = 5'(31 - i);
            tick();
            check_value($sformatf("zero_a_%0d", i), rda, 64'd0);
            check_value($sformatf("zero_b_%0d", 31 - i), rdb, 64'd0);
        end

        // Basic write/read on both ports.
        we = 1'b1; wa = 5'd5; wd = 64'hDEADBEEF_0000_1234;
        tick();
        we = 1'b0; ra_a = 5'd5; ra_b = 5'd5;
        tick();
        check_value("x5_port_a", rda, 64'hDEADBEEF_0000_1234);
        check_value("x5_port_b", rdb, 64'hDEADBEEF_0000_1234);

        // x0 hardwired, including a same-cycle write/read of x0.
        we = 1'b1; wa = 5'd0; wd = 64'hFFFF_FFFF_FFFF_FFFF; ra_a = 5'd0; ra_b = 5'd5;
        tick();
        check_value("x0_same_cycle", rda, 64'd0);
        we = 1'b0;
        tick();
        check_value("x0_after_write", rda, 64'd0);
        check_value("x5_still", rdb, 64'hDEADBEEF_0000_1234);

        // Write/read collision on x7.
        we = 1'b1; wa = 5'd7; wd = 64'h11;
        tick();
        wd = 64'h22; ra_a = 5'd7; ra_b = 5'd5;
        tick();
`ifdef REGFILE_BYPASS_EN
        exp_byp = 64'h22;
`else
        exp_byp = 64'h11;
`endif
        check_value("x7_collision", rda, exp_byp);
        we = 1'b0;
        tick();
        check_value("x7_next_read", rda, 64'h22);

        // Asynchronous reset mid-cycle.
        we = 1'b1; wa = 5'd3; wd = 64'hAB;
        tick();
        we = 1'b0; ra_a = 5'd3; ra_b = 5'd3;
        tick();
        check_value("x3_before_rst", rda, 64'hAB);
        #2;
        rst = 1'b1;
        #1;
        check_value("midrst_ready", {63'd0, rdy}, 64'd0);
        check_value("midrst_rd_a", rda, 64'd0);
        check_value("midrst_rd_b", rdb, 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 31) check_value("reclear_not_ready", {63'd0, rdy}, 64'd0);
        end
        check_value("reclear_ready", {63'd0, rdy}, 64'd1);
        tick();
        check_value("x3_after_reclear", rda, 64'd0);
        check_value("x3_after_reclear_b", rdb, 64'd0);

        // Odd depth: out-of-range address 30 on the 24-entry instance.
        we24 = 1'b1; wa24 = 5'd23; wd24 = 64'h77;
        tick();
        wa24 = 5'd30; wd24 = 64'h55; ra24_a = 5'd30; ra24_b = 5'd23;
        tick();
        check_value("odd_oor_same_cycle", rda24, 64'd0);
        check_value("odd_x23_read", rdb24, 64'h77);
        we24 = 1'b0;
        tick();
        check_value("odd_oor_read", rda24, 64'd0);
        check_value("odd_x23_intact", rdb24, 64'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
